// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator / capture pair: counter sizing,
// capture FSM encoding, the edge-detector bundle and the stuck duty convention.
package pwm_pkg;

    localparam int TPWM_NOMINAL = 10;

    // Capture FSM encoding, kept as plain constants so older blocks can share it.
    localparam logic [1:0] ST_ACQ   = 2'd0;
    localparam logic [1:0] ST_MEAS  = 2'd1;
    localparam logic [1:0] ST_STUCK = 2'd2;

    typedef struct packed {
        logic s;
        logic rise;
        logic fall;
    } edge_t;

    function automatic int cnt_width(input int tmax);
        return $clog2(tmax + 1);
    endfunction

    // A stuck-low line reads as duty 0, a stuck-high line as a full period.
    function automatic int stuck_duty(input int tpwm, input logic level);
        return level ? tpwm : 0;
    endfunction

endpackage

// File: rtl/pwm_sync.sv
// Multi-flop synchronizer for an asynchronous level, plus a one-clock history
// register giving single-cycle rise/fall pulses in the clock domain.
module pwm_sync
    import pwm_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic  clock,
    input  logic  resetn,
    input  logic  din,
    output edge_t ev
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   s_w;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s_w = sync_q[SYNC_STAGES-1];
    assign ev  = '{s: s_w, rise: s_w & ~prev_q, fall: ~s_w & prev_q};

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of an asynchronous PWM input, one report per
// period, with a timeout report when the line stops toggling.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int  TPWM        = TPWM_NOMINAL,
    parameter int  TMAX        = 4 * TPWM,
    parameter int  SYNC_STAGES = 2,
    localparam int CW          = cnt_width(TMAX)
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          iPWM,
    output logic [CW-1:0] oDC,
    output logic [CW-1:0] oPeriod,
    output logic          oValid,
    output logic          oStuck
);

    localparam logic [CW-1:0] TMAX_C = CW'(TMAX);

    edge_t         ev;
    logic [1:0]    state;
    logic [CW-1:0] pcnt;
    logic [CW-1:0] hcnt;
    logic          at_tmax;

    pwm_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clock  (clock),
        .resetn (resetn),
        .din    (iPWM),
        .ev     (ev)
    );

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v >= TMAX_C) ? v : v + 1'b1;
    endfunction

    assign at_tmax = (pcnt == TMAX_C);

    // oValid is a one-cycle strobe with no ready: a consumer must take
    // oDC/oPeriod/oStuck in the strobe cycle (they then hold until the next one).
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_ACQ;
            pcnt    <= '0;
            hcnt    <= '0;
            oDC     <= '0;
            oPeriod <= '0;
            oValid  <= 1'b0;
            oStuck  <= 1'b0;
        end else begin
            oValid <= 1'b0;
            case (state)
                ST_STUCK: begin
                    if (ev.rise) begin
                        state <= ST_MEAS;
                        pcnt  <= CW'(1);
                        hcnt  <= CW'(1);
                    end else if (ev.fall) begin
                        state <= ST_ACQ;
                        pcnt  <= '0;
                        hcnt  <= '0;
                    end
                end
                default: begin
                    if (ev.rise) begin
                        // A rise wins over a simultaneous timeout; in ACQ the
                        // period just ended was partial and is dropped.
                        if (state == ST_MEAS) begin
                            oPeriod <= pcnt;
                            oDC     <= hcnt;
                            oStuck  <= 1'b0;
                            oValid  <= 1'b1;
                        end
                        state <= ST_MEAS;
                        pcnt  <= CW'(1);
                        hcnt  <= CW'(1);
                    end else begin
                        pcnt <= sat_inc(pcnt);
                        if (ev.s) begin
                            hcnt <= sat_inc(hcnt);
                        end
                        if (at_tmax) begin
                            state   <= ST_STUCK;
                            oPeriod <= '0;
                            oDC     <= CW'(stuck_duty(TPWM, ev.s));
                            oStuck  <= 1'b1;
                            oValid  <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
